// File: rtl/hamming_frame_rx.sv
// Serial receiver that collects the code bytes of one Hamming frame from a UART-style line
// and presents the complete codeword to the parallel decoder with a one-cycle strobe.
module hamming_frame_rx #(
  parameter  int N            = 8,
  parameter  int CLKS_PER_BIT = 16,
  parameter  int GAP_BITS     = 16,
  localparam int BYTES        = N / 4 + ((N % 4 != 0) ? 1 : 0),
  localparam int LENG         = 8 * BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  output logic [LENG:1] hammed_data,
  output logic          frame_valid,
  output logic          frame_error,
  output logic          busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);
  localparam int BW        = $clog2(BYTES + 1);
  localparam int PART_W    = (BYTES > 1) ? LENG - 8 : 1;

  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] C_GAP     = GW'(GAP_LIMIT);
  localparam logic [BW-1:0] C_LAST    = BW'(BYTES - 1);

  logic              r_rx_meta;
  logic              r_rx_sync;
  logic              r_rx_prev;
  logic              w_fall;
  state_t            r_state;
  logic [CW-1:0]     r_clk_cnt;
  logic [GW-1:0]     r_gap_cnt;
  logic [2:0]        r_bit_cnt;
  logic [BW-1:0]     r_byte_cnt;
  logic [7:0]        r_shift;
  logic [PART_W:1]   r_buf;
  logic              r_armed;
  logic [LENG:1]     w_frame;

  // Idle-high line: synchronizer resets to 1 so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // Earlier bytes sit in r_buf in arrival order; the byte just received is appended below them.
  generate
    if (BYTES > 1) begin : g_multi
      assign w_frame = {r_buf, r_shift};
    end else begin : g_single
      assign w_frame = r_shift;
    end
  endgenerate

  assign busy = (r_byte_cnt != '0) || (r_state inside {S_START, S_DATA, S_STOP});

  // NOTE: sequential state uses non-blocking assignments only, so every decision in this
  // block sees the values from before the clock edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      // NOTE: the partial buffer is ordinary flops, so clearing it on reset is legal and
      // guarantees a stale half-frame can never be combined with fresh bytes.
      r_buf       <= '0;
      r_armed     <= 1'b1;
      hammed_data <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (r_rx_sync) r_armed <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_fall && r_armed) begin
            r_state   <= S_START;
            r_clk_cnt <= C_ONE;
          end
        end

        S_START: begin
          if (r_clk_cnt == C_HALF_M1) begin
            r_clk_cnt <= '0;
            if (!r_rx_sync) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else if (r_byte_cnt != '0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_clk_cnt == C_BIT_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
            else                   r_bit_cnt <= r_bit_cnt + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_clk_cnt == C_BIT_M1) begin
            r_clk_cnt <= '0;
            // r_shift[0] is the first data bit of the byte: the pad bit.
            if (!r_rx_sync || r_shift[0]) begin
              frame_error <= 1'b1;
              r_byte_cnt  <= '0;
              r_buf       <= '0;
              r_armed     <= 1'b0;
              r_state     <= S_IDLE;
            end else if (r_byte_cnt == C_LAST) begin
              hammed_data <= w_frame;
              frame_valid <= 1'b1;
              r_byte_cnt  <= '0;
              r_buf       <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_buf      <= w_frame[PART_W:1];
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_gap_cnt  <= '0;
              r_state    <= S_GAP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (w_fall) begin
            r_state   <= S_START;
            r_clk_cnt <= C_ONE;
          end else if (r_gap_cnt == C_GAP) begin
            frame_error <= 1'b1;
            r_byte_cnt  <= '0;
            r_buf       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
